// File: rtl/fw_pkg.sv
// fw_pkg: shared encodings and record layouts for the firewall rule sequencer
package fw_pkg;
  typedef enum logic [2:0] {
    FS_SRC_IP   = 3'd0,
    FS_SRC_MASK = 3'd1,
    FS_DST_IP   = 3'd2,
    FS_DST_MASK = 3'd3,
    FS_PORTS    = 3'd4,
    FS_CTRL     = 3'd5
  } field_sel_e;
  typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_RESP} state_e;
  localparam int ENABLE_BIT = 9;
  localparam int ACTION_BIT = 8;
  localparam logic ACT_ACCEPT = 1'b1;
  localparam logic ACT_DROP = 1'b0;
  typedef struct packed {
    logic [31:0] src_ip;
    logic [31:0] src_mask;
    logic [31:0] dst_ip;
    logic [31:0] dst_mask;
    logic [15:0] sport;
    logic [15:0] dport;
    logic [7:0]  proto;
    logic        enable;
    logic        action;
  } rule_t;
  typedef struct packed {
    logic [31:0] src_ip;
    logic [31:0] dst_ip;
    logic [15:0] src_port;
    logic [15:0] dst_port;
    logic [7:0]  proto;
  } tuple_t;
endpackage

// File: rtl/fw_rule_match.sv
// fw_rule_match: combinational compare of one rule against one 5-tuple
// Ports: rule (table entry), tuple (latched header) in; match, action out.
// Zero-valued port/proto fields in the rule act as wildcards.
module fw_rule_match
  import fw_pkg::*;
(
  input  rule_t  rule,
  input  tuple_t tuple,
  output logic   match,
  output logic   action
);
  assign match = rule.enable
    && ((tuple.src_ip ^ rule.src_ip) & rule.src_mask) == '0
    && ((tuple.dst_ip ^ rule.dst_ip) & rule.dst_mask) == '0
    && (rule.sport == '0 || rule.sport == tuple.src_port)
    && (rule.dport == '0 || rule.dport == tuple.dst_port)
    && (rule.proto == '0 || rule.proto == tuple.proto);
  assign action = rule.action;
endmodule

// File: rtl/fw_rule_sequencer.sv
// fw_rule_sequencer: latches a 5-tuple and scans the rule table one entry per cycle
// Ports: clk, reset (async, active-low); tuple_* handshake + header fields in;
// cfg_* rule field writes (taken only while idle); dec_* decision handshake out;
// cnt_accepted/cnt_dropped count completed decisions.
module fw_rule_sequencer
  import fw_pkg::*;
#(
  parameter int NUM_RULES      = 16,
  parameter int RULE_IDX_WIDTH = 4,
  parameter bit DEFAULT_ACTION = 1'b0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      tuple_valid,
  output logic                      tuple_rdy,
  input  logic [31:0]               src_ip,
  input  logic [31:0]               dst_ip,
  input  logic [15:0]               src_port,
  input  logic [15:0]               dst_port,
  input  logic [7:0]                proto,
  input  logic                      cfg_wr_en,
  output logic                      cfg_rdy,
  input  logic [RULE_IDX_WIDTH-1:0] cfg_addr,
  input  logic [2:0]                cfg_field_sel,
  input  logic [31:0]               cfg_wr_data,
  output logic                      dec_valid,
  input  logic                      dec_rdy,
  output logic                      dec_accept,
  output logic                      dec_hit,
  output logic [RULE_IDX_WIDTH-1:0] dec_rule_idx,
  output logic [31:0]               cnt_accepted,
  output logic [31:0]               cnt_dropped
);
  localparam logic [RULE_IDX_WIDTH-1:0] LAST_IDX = RULE_IDX_WIDTH'(NUM_RULES - 1);
  state_e state, state_nxt;
  rule_t rules [2**RULE_IDX_WIDTH];
  tuple_t tuple;
  logic [RULE_IDX_WIDTH-1:0] idx;
  logic match, action, scan_done;
  // Held low while reset is asserted so upstream never sees ready during reset.
  assign tuple_rdy = reset && state == ST_IDLE;
  assign cfg_rdy = tuple_rdy;
  assign dec_valid = state == ST_RESP;
  assign scan_done = match || idx == LAST_IDX;
  fw_rule_match u_match (.rule(rules[idx]), .tuple(tuple), .match(match), .action(action));
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= ST_IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    state_nxt = state == ST_IDLE ? (tuple_valid ? ST_SCAN : ST_IDLE)
              : state == ST_SCAN ? (scan_done ? ST_RESP : ST_SCAN)
              : (dec_rdy ? ST_IDLE : ST_RESP);
  end
  // Table holds a power-of-two number of entries; entries past NUM_RULES are never scanned.
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      for (int i = 0; i < 2**RULE_IDX_WIDTH; i++) rules[i] <= '0;
    end else if (cfg_wr_en && cfg_rdy) begin
      case (cfg_field_sel)
        FS_SRC_IP:   rules[cfg_addr].src_ip <= cfg_wr_data;
        FS_SRC_MASK: rules[cfg_addr].src_mask <= cfg_wr_data;
        FS_DST_IP:   rules[cfg_addr].dst_ip <= cfg_wr_data;
        FS_DST_MASK: rules[cfg_addr].dst_mask <= cfg_wr_data;
        FS_PORTS: begin
          rules[cfg_addr].sport <= cfg_wr_data[31:16];
          rules[cfg_addr].dport <= cfg_wr_data[15:0];
        end
        FS_CTRL: begin
          rules[cfg_addr].enable <= cfg_wr_data[ENABLE_BIT];
          rules[cfg_addr].action <= cfg_wr_data[ACTION_BIT];
          rules[cfg_addr].proto <= cfg_wr_data[7:0];
        end
        default: ;
      endcase
    end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      tuple <= '0;
      idx <= '0;
      dec_accept <= 1'b0;
      dec_hit <= 1'b0;
      dec_rule_idx <= '0;
      cnt_accepted <= '0;
      cnt_dropped <= '0;
    end else begin
      if (tuple_rdy && tuple_valid) begin
        tuple <= {src_ip, dst_ip, src_port, dst_port, proto};
        idx <= '0;
      end else if (state == ST_SCAN) begin
        if (scan_done) begin
          dec_hit <= match;
          dec_accept <= match ? action : DEFAULT_ACTION;
          dec_rule_idx <= match ? idx : '0;
        end else idx <= idx + 1'b1;
      end
      if (dec_valid && dec_rdy) begin
        cnt_accepted <= cnt_accepted + 32'(dec_accept == ACT_ACCEPT);
        cnt_dropped <= cnt_dropped + 32'(dec_accept == ACT_DROP);
      end
    end
endmodule

// File: tb/tb_fw_rule_sequencer.sv
// tb_fw_rule_sequencer: scoreboard bench for the rule sequencer
module tb_fw_rule_sequencer;
  import fw_pkg::*;
  typedef struct packed {
    logic       acc;
    logic       hit;
    logic [3:0] idx;
  } dec_t;
  localparam logic [31:0] T_SRC = 32'h0A00_0001;
  localparam logic [31:0] T_DST = 32'h0A00_0002;
  logic clk = 1'b0;
  logic reset, tuple_valid, tuple_rdy, cfg_wr_en, cfg_rdy, dec_valid, dec_rdy, dec_accept, dec_hit;
  logic [31:0] src_ip, dst_ip, cfg_wr_data, cnt_accepted, cnt_dropped;
  logic [15:0] src_port, dst_port;
  logic [7:0] proto;
  logic [3:0] cfg_addr, dec_rule_idx;
  logic [2:0] cfg_field_sel;
  int checks = 0, failures = 0, cyc = 0;
  int m_acc = 0, m_drop = 0;
  dec_t sb[$];
  dec_t mon_e;
  fw_rule_sequencer #(.NUM_RULES(16), .RULE_IDX_WIDTH(4), .DEFAULT_ACTION(1'b0)) dut (
    .clk(clk), .reset(reset), .tuple_valid(tuple_valid), .tuple_rdy(tuple_rdy),
    .src_ip(src_ip), .dst_ip(dst_ip), .src_port(src_port), .dst_port(dst_port), .proto(proto),
    .cfg_wr_en(cfg_wr_en), .cfg_rdy(cfg_rdy), .cfg_addr(cfg_addr), .cfg_field_sel(cfg_field_sel),
    .cfg_wr_data(cfg_wr_data), .dec_valid(dec_valid), .dec_rdy(dec_rdy), .dec_accept(dec_accept),
    .dec_hit(dec_hit), .dec_rule_idx(dec_rule_idx), .cnt_accepted(cnt_accepted), .cnt_dropped(cnt_dropped)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk)
    if (reset && dec_valid && dec_rdy) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL sb_underflow got acc=%0b hit=%0b idx=%0d with nothing expected", dec_accept, dec_hit, dec_rule_idx);
      end else begin
        mon_e = sb.pop_front();
        if ({dec_accept, dec_hit, dec_rule_idx} !== {mon_e.acc, mon_e.hit, mon_e.idx}) begin
          failures++;
          $display("FAIL decision got acc=%0b hit=%0b idx=%0d exp acc=%0b hit=%0b idx=%0d",
                   dec_accept, dec_hit, dec_rule_idx, mon_e.acc, mon_e.hit, mon_e.idx);
        end
        if (mon_e.acc) m_acc++;
        else m_drop++;
      end
    end
  function automatic dec_t mk(input logic a, input logic h, input logic [3:0] i);
    return '{acc: a, hit: h, idx: i};
  endfunction
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic cfg_wr(input logic [3:0] a, input logic [2:0] s, input logic [31:0] d);
    cfg_wr_en = 1'b1; cfg_addr = a; cfg_field_sel = s; cfg_wr_data = d;
    tick;
    cfg_wr_en = 1'b0;
  endtask
  task automatic set_tuple(input logic [31:0] s, input logic [31:0] d, input logic [15:0] sp, input logic [15:0] dp, input logic [7:0] p);
    src_ip = s; dst_ip = d; src_port = sp; dst_port = dp; proto = p;
  endtask
  task automatic send(input dec_t e, input int exp_lat);
    int n, lat;
    n = 0;
    while (!tuple_rdy && n < 40) begin tick; n++; end
    sb.push_back(e);
    tuple_valid = 1'b1;
    tick;
    tuple_valid = 1'b0;
    cfg_wr_en = 1'b0;
    lat = 1;
    while (!dec_valid && lat < 40) begin tick; lat++; end
    checks++;
    if (lat != exp_lat) begin
      failures++;
      $display("FAIL latency got %0d exp %0d", lat, exp_lat);
    end
  endtask
  task automatic do_tuple(input dec_t e, input int exp_lat);
    send(e, exp_lat);
    tick;
    checks++;
    if (cnt_accepted !== 32'(m_acc) || cnt_dropped !== 32'(m_drop)) begin
      failures++;
      $display("FAIL counters got acc=%0d drop=%0d exp acc=%0d drop=%0d", cnt_accepted, cnt_dropped, m_acc, m_drop);
    end
  endtask
  task automatic test_reset;
    reset = 1'b0; tuple_valid = 1'b0; cfg_wr_en = 1'b0; dec_rdy = 1'b1;
    cfg_addr = '0; cfg_field_sel = '0; cfg_wr_data = '0;
    set_tuple(T_SRC, T_DST, 16'd1234, 16'd80, 8'd6);
    repeat (2) tick;
    checks++;
    if ({tuple_rdy, cfg_rdy, dec_valid, dec_accept, dec_hit, dec_rule_idx} !== 9'b0 || cnt_accepted !== 0 || cnt_dropped !== 0) begin
      failures++;
      $display("FAIL reset_outputs got rdy=%0b cfg=%0b v=%0b a=%0b h=%0b i=%0d ca=%0d cd=%0d exp all 0",
               tuple_rdy, cfg_rdy, dec_valid, dec_accept, dec_hit, dec_rule_idx, cnt_accepted, cnt_dropped);
    end
    reset = 1'b1;
    tick;
    checks++;
    if (tuple_rdy !== 1'b1 || cfg_rdy !== 1'b1) begin
      failures++;
      $display("FAIL idle_ready got tuple_rdy=%0b cfg_rdy=%0b exp 1 1", tuple_rdy, cfg_rdy);
    end
  endtask
  task automatic test_default_miss;
    set_tuple(T_SRC, T_DST, 16'd1234, 16'd80, 8'd6);
    do_tuple(mk(0, 0, 0), 17);
  endtask
  task automatic test_single_rule;
    cfg_wr(3, FS_SRC_IP, 32'h0A00_0000);
    cfg_wr(3, FS_SRC_MASK, 32'hFFFF_FF00);
    cfg_wr(3, FS_PORTS, 32'h0000_0050);
    cfg_wr(3, FS_CTRL, 32'h306);
    do_tuple(mk(1, 1, 3), 5);
    set_tuple(T_SRC, T_DST, 16'd1234, 16'd81, 8'd6);
    do_tuple(mk(0, 0, 0), 17);
  endtask
  task automatic test_priority;
    cfg_wr(3, FS_CTRL, 32'h0);
    cfg_wr(2, FS_CTRL, 32'h200);
    cfg_wr(5, FS_PORTS, 32'h04D2_0000);
    cfg_wr(5, FS_CTRL, 32'h300);
    set_tuple(T_SRC, T_DST, 16'd1234, 16'd80, 8'd6);
    do_tuple(mk(0, 1, 2), 4);
    cfg_wr(2, FS_CTRL, 32'h000);
    do_tuple(mk(1, 1, 5), 7);
  endtask
  task automatic test_backpressure;
    int acc0, drop0;
    dec_rdy = 1'b0;
    send(mk(1, 1, 5), 7);
    acc0 = m_acc; drop0 = m_drop;
    repeat (10) begin
      tick;
      checks++;
      if (dec_valid !== 1'b1 || {dec_accept, dec_hit, dec_rule_idx} !== 6'b11_0101 || tuple_rdy !== 1'b0 || cfg_rdy !== 1'b0
          || cnt_accepted !== 32'(acc0) || cnt_dropped !== 32'(drop0)) begin
        failures++;
        $display("FAIL hold got v=%0b a=%0b h=%0b i=%0d rdy=%0b cfg=%0b ca=%0d cd=%0d exp v=1 a=1 h=1 i=5 rdy=0 cfg=0 ca=%0d cd=%0d",
                 dec_valid, dec_accept, dec_hit, dec_rule_idx, tuple_rdy, cfg_rdy, cnt_accepted, cnt_dropped, acc0, drop0);
      end
    end
    dec_rdy = 1'b1;
    tick;
    checks++;
    if (tuple_rdy !== 1'b1 || dec_valid !== 1'b0 || cnt_accepted !== 32'(acc0 + 1) || cnt_dropped !== 32'(drop0)) begin
      failures++;
      $display("FAIL release got rdy=%0b v=%0b ca=%0d cd=%0d exp rdy=1 v=0 ca=%0d cd=%0d",
               tuple_rdy, dec_valid, cnt_accepted, cnt_dropped, acc0 + 1, drop0);
    end
  endtask
  task automatic test_cfg_during_scan;
    int n;
    cfg_wr(0, FS_CTRL, 32'h211);
    set_tuple(T_SRC, T_DST, 16'd1234, 16'd80, 8'd6);
    sb.push_back(mk(1, 1, 5));
    tuple_valid = 1'b1;
    tick;
    tuple_valid = 1'b0;
    cfg_wr_en = 1'b1; cfg_addr = 0; cfg_field_sel = FS_CTRL; cfg_wr_data = 32'h311;
    checks++;
    if (cfg_rdy !== 1'b0) begin
      failures++;
      $display("FAIL scan_cfg_rdy got %0b exp 0", cfg_rdy);
    end
    tick;
    cfg_wr_en = 1'b0;
    n = 0;
    while (!dec_valid && n < 40) begin tick; n++; end
    checks++;
    if (dec_valid !== 1'b1) begin
      failures++;
      $display("FAIL scan_timeout got dec_valid=%0b exp 1", dec_valid);
    end
    tick;
    set_tuple(T_SRC, T_DST, 16'd1234, 16'd80, 8'd17);
    do_tuple(mk(0, 1, 0), 2);
    cfg_wr_en = 1'b1; cfg_addr = 0; cfg_field_sel = FS_CTRL; cfg_wr_data = 32'h311;
    do_tuple(mk(1, 1, 0), 2);
  endtask
  task automatic test_back_to_back;
    int last, n;
    last = -1; n = 0;
    tuple_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (tuple_rdy) begin
        sb.push_back(mk(1, 1, 0));
        if (last >= 0) begin
          checks++;
          if (cyc - last != 3) begin
            failures++;
            $display("FAIL b2b_period got %0d exp 3", cyc - last);
          end
        end
        last = cyc;
        n++;
      end
      tick;
    end
    tuple_valid = 1'b0;
    repeat (4) tick;
    checks++;
    if (n != 4 || sb.size() != 0) begin
      failures++;
      $display("FAIL b2b_count got accepts=%0d pending=%0d exp 4 0", n, sb.size());
    end
  endtask
  task automatic test_reset_mid_scan;
    logic seen;
    set_tuple(T_SRC, T_DST, 16'd1, 16'd81, 8'd6);
    tuple_valid = 1'b1;
    tick;
    tuple_valid = 1'b0;
    repeat (7) tick;
    reset = 1'b0;
    #1;
    sb.delete();
    m_acc = 0; m_drop = 0;
    checks++;
    if (dec_valid !== 1'b0 || tuple_rdy !== 1'b0 || cnt_accepted !== 0 || cnt_dropped !== 0) begin
      failures++;
      $display("FAIL mid_reset got v=%0b rdy=%0b ca=%0d cd=%0d exp 0 0 0 0", dec_valid, tuple_rdy, cnt_accepted, cnt_dropped);
    end
    repeat (2) tick;
    reset = 1'b1;
    seen = 1'b0;
    repeat (20) begin
      tick;
      if (dec_valid) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      failures++;
      $display("FAIL aborted_decision got dec_valid seen=%0b exp 0", seen);
    end
    set_tuple(T_SRC, T_DST, 16'd1234, 16'd80, 8'd17);
    do_tuple(mk(0, 0, 0), 17);
  endtask
  initial begin
    test_reset;
    test_default_miss;
    test_single_rule;
    test_priority;
    test_backpressure;
    test_cfg_during_scan;
    test_back_to_back;
    test_reset_mid_scan;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL sb_leftover got %0d exp 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fw_rule_sequencer.md
Name: fw_rule_sequencer

Overview:
- Decision controller that sits directly after the header extractor in the firewall pipeline.
- Latches one 5-tuple (src/dst IP, src/dst port, protocol) per handshake and scans a register-configured rule table one rule per cycle.
- Lowest-index enabled matching rule wins; if no rule matches, DEFAULT_ACTION applies.
- Returns accept/drop and rule index over a valid/ready interface, and keeps accept/drop counters for the register block.

Parameters:
- NUM_RULES, 16, number of rule entries (2..64).
- RULE_IDX_WIDTH, 4, log2(NUM_RULES); width of rule index and cfg address.
- DEFAULT_ACTION, 0, action on miss (1=accept, 0=drop).

Ports:
- clk  in  1  single clock, posedge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- tuple_valid  in  1  tuple present.
- tuple_rdy  out  1  block can latch tuple.
- src_ip  in  32  tuple source IP.
- dst_ip  in  32  tuple destination IP.
- src_port  in  16  tuple L4 source port.
- dst_port  in  16  tuple L4 destination port.
- proto  in  8  tuple IP protocol.
- cfg_wr_en  in  1  rule field write strobe.
- cfg_rdy  out  1  writes accepted this cycle.
- cfg_addr  in  RULE_IDX_WIDTH  rule index.
- cfg_field_sel  in  3  field select.
- cfg_wr_data  in  32  field value.
- dec_valid  out  1  decision present.
- dec_rdy  in  1  downstream takes decision.
- dec_accept  out  1  1=forward, 0=drop.
- dec_hit  out  1  1=a rule matched.
- dec_rule_idx  out  RULE_IDX_WIDTH  matching rule index; 0 on miss.
- cnt_accepted  out  32  accepted-decision count.
- cnt_dropped  out  32  dropped-decision count.

Behaviour:
- Reset values: tuple_rdy=0, dec_valid=0, dec_accept=0, dec_hit=0, dec_rule_idx=0, cnt_*=0. All rule enable bits cleared; other rule fields 0. State=IDLE.
- Reset is asynchronous. Asserting it mid-scan or mid-response aborts the tuple; no decision is emitted and no counter moves.
- Rule fields, selected by cfg_field_sel:
  - 0: src_ip
  - 1: src_mask
  - 2: dst_ip
  - 3: dst_mask
  - 4: {src_port[31:16], dst_port[15:0]}; port 0 = wildcard
  - 5: {enable[9], action[8], proto[7:0]}; proto 0 = wildcard; bits above 9 ignored
  - 6,7: write ignored
- Match condition: enable && ((src_ip^r.src_ip)&r.src_mask)==0 && ((dst_ip^r.dst_ip)&r.dst_mask)==0 && (r.sport==0 || equal) && (r.dport==0 || equal) && (r.proto==0 || equal).
- State machine:
  - IDLE: tuple_rdy=1, cfg_rdy=1. On tuple_valid, latch the tuple, set idx=0, go to SCAN.
  - SCAN: compare rule[idx] against the latched tuple.
    - Match: capture hit=1, action, idx; go to RESP.
    - Miss with idx==NUM_RULES-1: hit=0, accept=DEFAULT_ACTION, idx=0; go to RESP.
    - Otherwise: idx+1.
  - RESP: dec_valid=1 with outputs held stable. When dec_rdy=1: go to IDLE and increment cnt_accepted or cnt_dropped at that edge.
- Latency from the accepting edge:
  - Hit at rule k: dec_valid rises k+2 cycles later.
  - Miss: dec_valid rises NUM_RULES+1 cycles later.
  - Minimum back-to-back tuple period is 3 cycles (hit at rule 0, dec_rdy tied high).
- Config writes:
  - Committed only when cfg_rdy=1 (IDLE). When cfg_rdy=0 they are dropped silently; the writer must check cfg_rdy.
  - A write and a tuple accept on the same edge: the write commits first and the scan sees the new value.
- Counters wrap 0xFFFFFFFF→0. Exactly one counter increments per decision handshake.
- tuple_rdy=0 in SCAN and RESP; backpressure propagates upstream.

Decomposition:
- Shared package fw_pkg:
  - field_sel encodings (FS_SRC_IP..FS_CTRL)
  - state encodings (ST_IDLE, ST_SCAN, ST_RESP)
  - rule record layout/bit positions (ENABLE_BIT=9, ACTION_BIT=8)
  - ACT_ACCEPT/ACT_DROP constants
- Sub-module fw_rule_match: purely combinational, one rule vs one tuple, outputs match and action. Instantiated once, fed from the table mux at idx.

Test Plan:
- Empty table, DEFAULT_ACTION=0; tuple 10.0.0.1→10.0.0.2, ports 1234/80, proto 6 → dec_valid after 17 cycles, accept=0, hit=0, idx=0, cnt_dropped=1.
- Rule 3 = src 10.0.0.0 / mask FFFFFF00, dst mask 0, ports 0/80, proto 6, enable, action=1; same tuple → dec_valid 5 cycles after accept, accept=1, hit=1, idx=3, cnt_accepted=1. Change dst_port to 81 → miss, drop.
- Rules 2 (drop) and 5 (accept) both match → idx=2, accept=0. Clear enable of rule 2 → idx=5, accept=1.
- Hold dec_rdy=0 for 10 cycles in RESP → dec_* stable, tuple_rdy=0, counters unchanged. Raise dec_rdy → exactly one counter increment, tuple_rdy=1 next cycle.
- Write rule 0 action during SCAN (cfg_rdy=0) → ignored; readback decision unchanged. Same write in IDLE, coincident with tuple accept → new value used.
- Assert reset during SCAN at idx=7 → dec_valid never asserts, counters 0, rule enables cleared. After release, a tuple produces a miss.
